// File: rtl/writeback_queue.sv
// Serialises ALU and load results onto the register file's single write port; flags pending writes for decode.
// Latency: push at edge k -> write asserted in cycle k+1 (registered output), one pop per cycle.
// Backpressure: in_ready = count <= DEPTH-2; pushes that do not fit are dropped and set sticky overflow.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          Clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          in_ready,
    output logic          write,
    output logic [AW-1:0] rd,
    output logic [DW-1:0] entradaWb,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic          pend_rs,
    output logic          pend_rt,
    output logic          overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);
    localparam logic [CW-1:0] TWO = CW'(2);
    localparam logic [PW-1:0] ONE_P = PW'(1);

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] dat;
    } entry_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] head, tail, tail_p1;
    logic [CW-1:0] count, space, n_req, n_acc, pop_c;
    logic          mem_q, alu_q, pop, drop;
    entry_t        first, second;
    logic [PW-1:0] off;
    logic          hit_rs, hit_rt;

    // Writes to $0 are architecturally no-ops, so they never take a slot.
    assign mem_q   = mem_valid && (mem_rd != '0);
    assign alu_q   = alu_valid && (alu_rd != '0);
    assign n_req   = {{(CW-1){1'b0}}, mem_q} + {{(CW-1){1'b0}}, alu_q};
    // Space is judged before this edge's pop; a slot freed by the pop is not reused until next edge.
    assign space   = DEPTH_C - count;
    assign drop    = n_req > space;
    assign n_acc   = drop ? space : n_req;
    assign pop     = count != '0;
    assign pop_c   = {{(CW-1){1'b0}}, pop};
    assign tail_p1 = tail + ONE_P;
    // The load is the older instruction, so it goes in first.
    assign first   = mem_q ? '{rd: mem_rd, dat: mem_data} : '{rd: alu_rd, dat: alu_data};
    assign second  = '{rd: alu_rd, dat: alu_data};
    assign in_ready = count <= READY_MAX;

    always_ff @(posedge Clk) begin
        if (!rst) begin
            if (n_acc != '0) q[tail] <= first;
            if (n_acc == TWO) q[tail_p1] <= second;
        end
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            write     <= 1'b0;
            rd        <= '0;
            entradaWb <= '0;
            overflow  <= 1'b0;
        end else begin
            tail  <= tail + n_acc[PW-1:0];
            count <= count + n_acc - pop_c;
            write <= pop;
            if (pop) begin
                rd        <= q[head].rd;
                entradaWb <= q[head].dat;
                head      <= head + ONE_P;
            end
            if (drop) overflow <= 1'b1;
        end
    end

    // A slot is live when its distance from head is below count.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if ({1'b0, off} < count) begin
                if (q[i].rd == rs) hit_rs = 1'b1;
                if (q[i].rd == rt) hit_rt = 1'b1;
            end
        end
    end

    assign pend_rs = (rs != '0) && (hit_rs || (write && (rd == rs)));
    assign pend_rt = (rt != '0) && (hit_rt || (write && (rd == rt)));
endmodule

// File: tb/tb_writeback_queue.sv
// Directed plus random stimulus for writeback_queue, checked against a queue-based reference model.
module tb_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          Clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_rd, mem_rd, rs, rt;
    logic [DW-1:0] alu_data, mem_data;
    logic          in_ready, write, pend_rs, pend_rt, overflow;
    logic [AW-1:0] rd;
    logic [DW-1:0] entradaWb;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic          m_write = 1'b0;
    logic [AW-1:0] m_rd = '0;
    logic [DW-1:0] m_dat = '0;
    logic          m_ovf = 1'b0;

    always #5 Clk = ~Clk;

    writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clk(Clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .in_ready(in_ready), .write(write), .rd(rd), .entradaWb(entradaWb),
        .rs(rs), .rt(rt), .pend_rs(pend_rs), .pend_rt(pend_rt), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pend_m(input logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
        return m_write && (m_rd == a);
    endfunction

    task automatic set_push(input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                            input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad);
        mem_valid = mv; mem_rd = mr; mem_data = md;
        alu_valid = av; alu_rd = ar; alu_data = ad;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare everything.
    task automatic step();
        @(posedge Clk);
        if (rst) begin
            mq.delete();
            m_write = 1'b0; m_rd = '0; m_dat = '0; m_ovf = 1'b0;
        end else begin
            bit   p;
            int   space;
            ent_t h;
            p = mq.size() > 0;
            space = DEPTH - mq.size();
            if (p) h = mq[0];
            if (mem_valid && mem_rd != '0) begin
                if (space > 0) begin mq.push_back('{mem_rd, mem_data}); space--; end
                else m_ovf = 1'b1;
            end
            if (alu_valid && alu_rd != '0) begin
                if (space > 0) begin mq.push_back('{alu_rd, alu_data}); space--; end
                else m_ovf = 1'b1;
            end
            if (p) begin
                void'(mq.pop_front());
                m_write = 1'b1; m_rd = h.rd; m_dat = h.d;
            end else begin
                m_write = 1'b0;
            end
        end
        #1;
        chk("write", 64'(write), 64'(m_write));
        chk("rd", 64'(rd), 64'(m_rd));
        chk("entradaWb", 64'(entradaWb), 64'(m_dat));
        chk("in_ready", 64'(in_ready), 64'(mq.size() <= DEPTH - 2));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("pend_rs", 64'(pend_rs), 64'(pend_m(rs)));
        chk("pend_rt", 64'(pend_rt), 64'(pend_m(rt)));
    endtask

    initial begin
        rst = 1'b1; rs = '0; rt = '0;
        set_push(1'b1, 5'd4, 32'h11111111, 1'b1, 5'd3, 32'h22222222);
        step(); step();
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_data", 64'(entradaWb), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        set_push(1'b0, '0, '0, 1'b0, '0, '0);
        step(); step();
        chk("post_rst_nowrite", 64'(write), 64'd0);

        // Single push
        rs = 5'd1; rt = 5'd2;
        set_push(1'b0, '0, '0, 1'b1, 5'd1, 32'ha0a0a0a0);
        step();
        set_push(1'b0, '0, '0, 1'b0, '0, '0);
        chk("single_pend_k", 64'(pend_rs), 64'd1);
        step();
        chk("single_write", 64'(write), 64'd1);
        chk("single_rd", 64'(rd), 64'd1);
        chk("single_data", 64'(entradaWb), 64'ha0a0a0a0);
        chk("single_pend_k1", 64'(pend_rs), 64'd1);
        step();
        chk("single_once", 64'(write), 64'd0);
        chk("single_pend_clr", 64'(pend_rs), 64'd0);

        // Dual push: mem ahead of alu
        rs = 5'h1c;
        set_push(1'b1, 5'd2, 32'hffffffff, 1'b1, 5'h1c, 32'h19857328);
        step();
        set_push(1'b0, '0, '0, 1'b0, '0, '0);
        step();
        chk("dual_first_rd", 64'(rd), 64'd2);
        chk("dual_first_data", 64'(entradaWb), 64'hffffffff);
        step();
        chk("dual_second_write", 64'(write), 64'd1);
        chk("dual_second_rd", 64'(rd), 64'h1c);
        chk("dual_second_data", 64'(entradaWb), 64'h19857328);
        step();

        // $0 filter
        rs = '0;
        set_push(1'b0, '0, '0, 1'b1, 5'd0, 32'h753b9817);
        step();
        set_push(1'b0, '0, '0, 1'b0, '0, '0);
        chk("zero_pend", 64'(pend_rs), 64'd0);
        step();
        chk("zero_nowrite", 64'(write), 64'd0);

        // Fill and backpressure
        set_push(1'b1, 5'd5, 32'h5, 1'b1, 5'd6, 32'h6);
        step();
        set_push(1'b1, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8);
        step();
        chk("fill_in_ready_low", 64'(in_ready), 64'd0);
        set_push(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'ha);
        step();
        chk("fill_overflow", 64'(overflow), 64'd1);
        chk("fill_pop_order", 64'(rd), 64'd6);
        set_push(1'b0, '0, '0, 1'b0, '0, '0);
        rt = 5'd10;
        step();
        chk("drain_rd7", 64'(rd), 64'd7);
        chk("drain_ready_back", 64'(in_ready), 64'd1);
        chk("dropped_not_pend", 64'(pend_rt), 64'd0);
        step(); chk("drain_rd8", 64'(rd), 64'd8);
        step(); chk("drain_rd9", 64'(rd), 64'd9);
        step(); chk("drain_done", 64'(write), 64'd0);

        // Mid-operation reset with three entries queued
        set_push(1'b1, 5'd11, 32'hb, 1'b1, 5'd12, 32'hc);
        step();
        set_push(1'b1, 5'd13, 32'hd, 1'b1, 5'd14, 32'he);
        step();
        set_push(1'b0, '0, '0, 1'b0, '0, '0);
        rst = 1'b1;
        step();
        chk("midrst_write", 64'(write), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        step(); chk("midrst_no_stale", 64'(write), 64'd0);
        set_push(1'b0, '0, '0, 1'b1, 5'h1f, 32'h753b9817);
        step();
        set_push(1'b0, '0, '0, 1'b0, '0, '0);
        step();
        chk("midrst_new_write", 64'(write), 64'd1);
        chk("midrst_new_rd", 64'(rd), 64'h1f);
        chk("midrst_new_data", 64'(entradaWb), 64'h753b9817);
        step();

        // Random traffic, mostly honouring in_ready, with rare forced pushes and resets
        for (int n = 0; n < 400; n++) begin
            logic force_push;
            force_push = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            mem_valid = ($urandom_range(0, 1) == 1) && (in_ready || force_push);
            alu_valid = ($urandom_range(0, 1) == 1) && (in_ready || force_push);
            mem_rd = AW'($urandom_range(0, 7));
            alu_rd = AW'($urandom_range(0, 7));
            mem_data = $urandom;
            alu_data = $urandom;
            rs = AW'($urandom_range(0, 7));
            rt = AW'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
